spi_burst_ram: RTL and testbench

Parametrised single-port RAM slave that sits behind the SPI slave's deserialiser and decodes 2-bit-command-tagged words into address and data operations. It generalises the 8-bit RAM to independent data/address widths and arbitrary depth. It adds burst auto-increment with wrap, range checking, read-sequence tracking and sticky error flags. Output words return to the SPI slave for serialisation on MISO.

---
 rtl/spi_burst_ram.sv | 141 ++++++++++++++
 tb/tb_spi_burst_ram.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/spi_burst_ram.sv
// Command-tagged single-port RAM slave behind an SPI deserialiser: address/data decode, sticky errors.
// Optional burst auto-increment of both pointers when SPI_RAM_AUTOINC_EN is defined.
module spi_burst_ram #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned MEM_DEPTH  = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH+1:0] din,
   input  logic                  rx_valid,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  tx_valid,
   output logic                  addr_err,
   output logic                  seq_err
);

   localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned CMP_W = ADDR_WIDTH + 1;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [IDX_W-1:0]      wr_ptr;
   logic [IDX_W-1:0]      rd_ptr;
   logic                  wr_armed;
   logic                  rd_armed;

   logic [1:0]            cmd;
   logic [ADDR_WIDTH-1:0] addr_field;
   logic [DATA_WIDTH-1:0] payload;
   logic                  addr_ok;
   logic                  do_wr_addr;
   logic                  do_rd_addr;
   logic                  do_write;
   logic                  do_read;
   logic                  set_addr_err;
   logic                  set_seq_err;

   // Wrap by compare so non-power-of-two depths stay in range.
   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
      if (p == IDX_W'(MEM_DEPTH - 1))
         return '0;
      else
         return p + IDX_W'(1);
   endfunction

   // Command decode.
   always_comb begin
      cmd          = din[DATA_WIDTH+1:DATA_WIDTH];
      payload      = din[DATA_WIDTH-1:0];
      addr_field   = din[ADDR_WIDTH-1:0];
      addr_ok      = (CMP_W'(addr_field) < CMP_W'(MEM_DEPTH));
      do_wr_addr   = 1'b0;
      do_rd_addr   = 1'b0;
      do_write     = 1'b0;
      do_read      = 1'b0;
      set_addr_err = 1'b0;
      set_seq_err  = 1'b0;
      if (rx_valid) begin
         unique case (cmd)
            CMD_WR_ADDR: begin
               do_wr_addr   = addr_ok;
               set_addr_err = !addr_ok;
            end
            CMD_WR_DATA: begin
               do_write    = wr_armed;
               set_seq_err = !wr_armed;
            end
            CMD_RD_ADDR: begin
               do_rd_addr   = addr_ok;
               set_addr_err = !addr_ok;
            end
            CMD_RD_DATA: begin
               do_read     = rd_armed;
               set_seq_err = !rd_armed;
            end
            default: ;
         endcase
      end
   end

   // Storage array is intentionally left unreset.
   always_ff @(posedge clk) begin
      if (do_write)
         mem[wr_ptr] <= payload;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout     <= '0;
         tx_valid <= 1'b0;
         addr_err <= 1'b0;
         seq_err  <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         wr_armed <= 1'b0;
         rd_armed <= 1'b0;
      end else begin
         tx_valid <= do_read;
         if (do_read)
            dout <= mem[rd_ptr];

         if (do_wr_addr) begin
            wr_ptr   <= IDX_W'(addr_field);
            wr_armed <= 1'b1;
         end
         if (do_rd_addr) begin
            rd_ptr   <= IDX_W'(addr_field);
            rd_armed <= 1'b1;
         end
`ifdef SPI_RAM_AUTOINC_EN
         if (do_write)
            wr_ptr <= ptr_inc(wr_ptr);
         if (do_read)
            rd_ptr <= ptr_inc(rd_ptr);
`endif

         // A new error in the same cycle as err_clr leaves the flag set.
         if (err_clr) begin
            addr_err <= 1'b0;
            seq_err  <= 1'b0;
         end
         if (set_addr_err)
            addr_err <= 1'b1;
         if (set_seq_err)
            seq_err <= 1'b1;
      end
   end

`ifndef SPI_RAM_AUTOINC_EN
   logic unused_inc;
   assign unused_inc = ^ptr_inc(wr_ptr);
`endif

endmodule

// File: tb/tb_spi_burst_ram.sv
// Directed vector bench for spi_burst_ram (DATA_WIDTH=8, ADDR_WIDTH=8, MEM_DEPTH=15).
module tb_spi_burst_ram;

   localparam logic [1:0] WA = 2'b00;
   localparam logic [1:0] WD = 2'b01;
   localparam logic [1:0] RA = 2'b10;
   localparam logic [1:0] RD = 2'b11;

`ifdef SPI_RAM_AUTOINC_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [9:0] din;
   logic       rx_valid;
   logic       err_clr;
   logic [7:0] dout;
   logic       tx_valid;
   logic       addr_err;
   logic       seq_err;

   int errors = 0;
   int checks = 0;

   spi_burst_ram #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(8),
      .MEM_DEPTH (15)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (din),
      .rx_valid(rx_valid),
      .err_clr (err_clr),
      .dout    (dout),
      .tx_valid(tx_valid),
      .addr_err(addr_err),
      .seq_err (seq_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       rst_n;
      logic       rx_valid;
      logic       err_clr;
      logic [9:0] din;
      logic [7:0] dout;
      logic       tx;
      logic       aerr;
      logic       serr;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic v, input logic c,
                               input logic [1:0] cm, input logic [7:0] pl,
                               input logic [7:0] ed, input logic et,
                               input logic ea, input logic es);
      vec_t x;
      x.rst_n = r; x.rx_valid = v; x.err_clr = c; x.din = {cm, pl};
      x.dout = ed; x.tx = et; x.aerr = ea; x.serr = es;
      vecs.push_back(x);
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [7:0] ed, input logic et,
                            input logic ea, input logic es);
      check({tag, " dout"}, dout, ed);
      check({tag, " tx_valid"}, 8'(tx_valid), 8'(et));
      check({tag, " addr_err"}, 8'(addr_err), 8'(ea));
      check({tag, " seq_err"}, 8'(seq_err), 8'(es));
   endtask

   task automatic drive(input logic r, input logic v, input logic c,
                        input logic [1:0] cm, input logic [7:0] pl);
      rst_n = r; rx_valid = v; err_clr = c; din = {cm, pl};
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] b1, b2;
      rst_n = 1'b0; rx_valid = 1'b0; err_clr = 1'b0; din = '0;
      b1 = AUTO ? 8'h11 : 8'h33;
      b2 = AUTO ? 8'h22 : 8'h33;

      // Reset with a live command on the bus, then unarmed read.
      add(0, 1, 0, RD, 8'hFF, 8'h00, 0, 0, 0);
      add(1, 1, 0, RD, 8'h00, 8'h00, 0, 0, 1);
      add(1, 0, 1, WA, 8'h00, 8'h00, 0, 0, 0);
      // Single write/read, one-cycle tx_valid.
      add(1, 1, 0, WA, 8'h05, 8'h00, 0, 0, 0);
      add(1, 1, 0, WD, 8'hA5, 8'h00, 0, 0, 0);
      add(1, 1, 0, RA, 8'h05, 8'h00, 0, 0, 0);
      add(1, 1, 0, RD, 8'h00, 8'hA5, 1, 0, 0);
      add(1, 0, 0, RD, 8'h00, 8'hA5, 0, 0, 0);
      // Burst at 13 wrapping through 14 to 0.
      add(1, 1, 0, WA, 8'h0D, 8'hA5, 0, 0, 0);
      add(1, 1, 0, WD, 8'h11, 8'hA5, 0, 0, 0);
      add(1, 1, 0, WD, 8'h22, 8'hA5, 0, 0, 0);
      add(1, 1, 0, WD, 8'h33, 8'hA5, 0, 0, 0);
      add(1, 1, 0, RA, 8'h0D, 8'hA5, 0, 0, 0);
      add(1, 1, 0, RD, 8'h00, b1,    1, 0, 0);
      add(1, 1, 0, RD, 8'h00, b2,    1, 0, 0);
      add(1, 1, 0, RD, 8'h00, 8'h33, 1, 0, 0);
      add(1, 0, 0, RD, 8'h00, 8'h33, 0, 0, 0);
      // rx_valid gating: ignored read neither strobes nor moves rd_ptr.
      add(1, 1, 0, RA, 8'h05, 8'h33, 0, 0, 0);
      add(1, 0, 0, RD, 8'h00, 8'h33, 0, 0, 0);
      add(1, 1, 0, RD, 8'h00, 8'hA5, 1, 0, 0);
      // Range errors leave wr_ptr intact.
      add(1, 1, 0, WA, 8'h04, 8'hA5, 0, 0, 0);
      add(1, 1, 0, WA, 8'h0F, 8'hA5, 0, 1, 0);
      add(1, 1, 0, WD, 8'h5A, 8'hA5, 0, 1, 0);
      add(1, 1, 0, RA, 8'h04, 8'hA5, 0, 1, 0);
      add(1, 1, 0, RD, 8'h00, 8'h5A, 1, 1, 0);
      add(1, 1, 0, WA, 8'h03, 8'h5A, 0, 1, 0);
      add(1, 1, 0, WD, 8'h7E, 8'h5A, 0, 1, 0);
      add(1, 1, 0, RA, 8'h03, 8'h5A, 0, 1, 0);
      add(1, 1, 0, RD, 8'h00, 8'h7E, 1, 1, 0);
      add(1, 1, 1, WA, 8'h14, 8'h7E, 0, 1, 0);
      add(1, 0, 1, WA, 8'h00, 8'h7E, 0, 0, 0);
      add(1, 1, 0, RA, 8'hFF, 8'h7E, 0, 1, 0);
      add(1, 0, 1, WA, 8'h00, 8'h7E, 0, 0, 0);
      // Last legal address MEM_DEPTH-1.
      add(1, 1, 0, WA, 8'h0E, 8'h7E, 0, 0, 0);
      add(1, 1, 0, WD, 8'hC3, 8'h7E, 0, 0, 0);
      add(1, 1, 0, RA, 8'h0E, 8'h7E, 0, 0, 0);
      add(1, 1, 0, RD, 8'h00, 8'hC3, 1, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].rx_valid, vecs[i].err_clr,
               vecs[i].din[9:8], vecs[i].din[7:0]);
         check_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].tx,
                   vecs[i].aerr, vecs[i].serr);
      end

      // Mid-burst reset: tx_valid must drop asynchronously.
      drive(1, 1, 0, RA, 8'h05);
      drive(1, 1, 0, RD, 8'h00);
      check_all("burst_rd", 8'hA5, 1, 0, 0);
      #3 rst_n = 1'b0;
      #1 check_all("async_rst", 8'h00, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 1, 0, RD, 8'h00);
      check_all("rd_after_rst", 8'h00, 0, 0, 1);
      drive(1, 0, 1, RD, 8'h00);
      drive(1, 1, 0, WD, 8'h99);
      check_all("wr_after_rst", 8'h00, 0, 0, 1);
      // Errors never block later valid commands.
      drive(1, 1, 0, RA, 8'h05);
      drive(1, 1, 0, RD, 8'h00);
      check_all("recover_rd", 8'hA5, 1, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
